// File: rtl/sbp_lookup_stage_v2.sv
// ---------------------------------------------------------------------------
// sbp_lookup_stage_v2
//
// One stage of a pipelined binary-trie longest-prefix-match lookup. Each
// instance owns one node memory (external, one-cycle read latency). A beat
// addressed to this stage either writes a node (update beat) or reads the
// node at location_i and walks one step down the trie (lookup beat). Beats
// for other stages pass through untouched. Latency is fixed at two cycles.
//
// Memory word layout, MSB first, no padding:
//   {prefix[KEY_BITS], prefix_len[PLEN_BITS], child_stage[STAGE_ID_BITS],
//    child_location[LOCATION_BITS], has_left, has_right}
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   valid_i .. result_i input beat (valid, update flag, key, bit position or
//                       prefix length, target stage, target location,
//                       best match so far or child pointer)
//   valid_o .. result_o the same beat two cycles later, updated by this stage
//   wr_en_o, rd_en_o    node memory write / read enables
//   addr_o, data_o      node memory address / write data
//   data_i              node memory read data, one cycle after rd_en_o
//   stat_clr_i          clear both statistics counters
//   lookup_cnt_o        saturating count of lookups served by this stage
//   hit_cnt_o           saturating count of those lookups that matched
//
// Flow control: a beat is transferred on every clock edge where valid_i is
// high; there is no ready signal and the stage never stalls, so the
// upstream stage may present one beat per cycle and valid_o marks the beat
// exactly two cycles later.
// ---------------------------------------------------------------------------
module sbp_lookup_stage_v2 #(
   parameter int STAGE_ID      = 1,
   parameter int STAGE_ID_BITS = 6,
   parameter int LOCATION_BITS = 11,
   parameter int KEY_BITS      = 32,
   parameter int CNT_BITS      = 32,
   parameter int PLEN_BITS     = $clog2(KEY_BITS) + 1,
   parameter int RESULT_BITS   = STAGE_ID_BITS + LOCATION_BITS,
   parameter int DATA_BITS     = KEY_BITS + PLEN_BITS + STAGE_ID_BITS + LOCATION_BITS + 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic                     update_i,
   input  logic [KEY_BITS-1:0]      key_i,
   input  logic [PLEN_BITS-1:0]     bit_pos_i,
   input  logic [STAGE_ID_BITS-1:0] stage_id_i,
   input  logic [LOCATION_BITS-1:0] location_i,
   input  logic [RESULT_BITS-1:0]   result_i,
   output logic                     valid_o,
   output logic                     update_o,
   output logic [KEY_BITS-1:0]      key_o,
   output logic [PLEN_BITS-1:0]     bit_pos_o,
   output logic [STAGE_ID_BITS-1:0] stage_id_o,
   output logic [LOCATION_BITS-1:0] location_o,
   output logic [RESULT_BITS-1:0]   result_o,
   output logic                     wr_en_o,
   output logic                     rd_en_o,
   output logic [LOCATION_BITS-1:0] addr_o,
   output logic [DATA_BITS-1:0]     data_o,
   input  logic [DATA_BITS-1:0]     data_i,
   input  logic                     stat_clr_i,
   output logic [CNT_BITS-1:0]      lookup_cnt_o,
   output logic [CNT_BITS-1:0]      hit_cnt_o
);

   // Only IPv4 and IPv6 key widths are meaningful for this trie.
   generate
      if (KEY_BITS != 32 && KEY_BITS != 128) begin : g_bad_key_bits
         $error("sbp_lookup_stage_v2: KEY_BITS must be 32 or 128");
      end
   endgenerate

   localparam logic [STAGE_ID_BITS-1:0] MY_STAGE   = STAGE_ID_BITS'(STAGE_ID);
   localparam logic [PLEN_BITS-1:0]     KEY_BITS_P = PLEN_BITS'(KEY_BITS);

   // Word field offsets (LSB positions).
   localparam int OFS_LOC    = 2;
   localparam int OFS_STAGE  = OFS_LOC + LOCATION_BITS;
   localparam int OFS_PLEN   = OFS_STAGE + STAGE_ID_BITS;
   localparam int OFS_PREFIX = OFS_PLEN + PLEN_BITS;

   // ------------------------------------------------------------------
   // Cycle N: select and issue the memory access.
   // ------------------------------------------------------------------
   logic sel;
   assign sel = valid_i && (stage_id_i == MY_STAGE);

   // Memory-side outputs are held at zero while reset is asserted so that
   // no stray write can land in the node table during reset.
   assign wr_en_o = sel && update_i && !rst;
   assign rd_en_o = sel && !update_i && !rst;
   assign addr_o  = rst ? '0 : location_i;
   // A written node always gets both child flags set; the child pointer is
   // carried in result_i.
   assign data_o  = wr_en_o ? {key_i, bit_pos_i, result_i, 2'b11} : '0;

   // ------------------------------------------------------------------
   // Stage 1 register: holds the beat while the memory read completes.
   // ------------------------------------------------------------------
   logic                     s1_valid;
   logic                     s1_update;
   logic                     s1_lookup;   // selected lookup: data_i is valid for it
   logic [KEY_BITS-1:0]      s1_key;
   logic [PLEN_BITS-1:0]     s1_bit_pos;
   logic [STAGE_ID_BITS-1:0] s1_stage_id;
   logic [LOCATION_BITS-1:0] s1_location;
   logic [RESULT_BITS-1:0]   s1_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_update   <= 1'b0;
         s1_lookup   <= 1'b0;
         s1_key      <= '0;
         s1_bit_pos  <= '0;
         s1_stage_id <= '0;
         s1_location <= '0;
         s1_result   <= '0;
      end else begin
         s1_valid    <= valid_i;
         s1_update   <= update_i;
         s1_lookup   <= sel && !update_i;
         s1_key      <= key_i;
         s1_bit_pos  <= bit_pos_i;
         s1_stage_id <= stage_id_i;
         s1_location <= location_i;
         s1_result   <= result_i;
      end
   end

   // ------------------------------------------------------------------
   // Cycle N+1: decode the node and take one trie step.
   // ------------------------------------------------------------------
   logic [KEY_BITS-1:0]      mem_prefix;
   logic [PLEN_BITS-1:0]     mem_plen;
   logic [STAGE_ID_BITS-1:0] mem_child_stage;
   logic [LOCATION_BITS-1:0] mem_child_loc;
   logic                     mem_has_left;
   logic                     mem_has_right;

   assign mem_prefix      = data_i[OFS_PREFIX +: KEY_BITS];
   assign mem_plen        = data_i[OFS_PLEN   +: PLEN_BITS];
   assign mem_child_stage = data_i[OFS_STAGE  +: STAGE_ID_BITS];
   assign mem_child_loc   = data_i[OFS_LOC    +: LOCATION_BITS];
   assign mem_has_left    = data_i[1];
   assign mem_has_right   = data_i[0];

   // Mask with the top prefix_len bits set. A right shift by KEY_BITS or
   // more clears the all-ones vector, so len >= KEY_BITS gives a full mask
   // and len 0 an empty one (always matches).
   logic [KEY_BITS-1:0] plen_mask;
   logic                match;
   assign plen_mask = ~({KEY_BITS{1'b1}} >> mem_plen);
   assign match     = (mem_plen <= KEY_BITS_P) &&
                      (((s1_key ^ mem_prefix) & plen_mask) == '0);

   // Branch bit counted from the MSB. Positions past the key select left.
   logic [KEY_BITS-1:0] key_shifted;
   logic                right_sel;
   assign key_shifted = s1_key << s1_bit_pos;
   assign right_sel   = (s1_bit_pos < KEY_BITS_P) ? key_shifted[KEY_BITS-1] : 1'b0;

   logic                     child_exists;
   logic [PLEN_BITS-1:0]     next_bit_pos;
   logic [LOCATION_BITS-1:0] next_location;
   assign child_exists  = right_sel ? mem_has_right : mem_has_left;
   assign next_bit_pos  = (&s1_bit_pos) ? s1_bit_pos : s1_bit_pos + PLEN_BITS'(1);
   assign next_location = mem_child_loc + LOCATION_BITS'(right_sel);

   // ------------------------------------------------------------------
   // Output register (cycle N+2) and statistics.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o    <= 1'b0;
         update_o   <= 1'b0;
         key_o      <= '0;
         bit_pos_o  <= '0;
         stage_id_o <= '0;
         location_o <= '0;
         result_o   <= '0;
      end else begin
         valid_o  <= s1_valid;
         update_o <= s1_update;
         key_o    <= s1_key;
         if (s1_lookup) begin
            bit_pos_o  <= next_bit_pos;
            location_o <= next_location;
            stage_id_o <= child_exists ? mem_child_stage : s1_stage_id;
            result_o   <= match ? {MY_STAGE, s1_location} : s1_result;
         end else begin
            bit_pos_o  <= s1_bit_pos;
            location_o <= s1_location;
            stage_id_o <= s1_stage_id;
            result_o   <= s1_result;
         end
      end
   end

   // Counters step together with the output register; clear wins over a
   // same-cycle increment, and both stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst || stat_clr_i) begin
         lookup_cnt_o <= '0;
         hit_cnt_o    <= '0;
      end else begin
         if (s1_lookup && !(&lookup_cnt_o)) begin
            lookup_cnt_o <= lookup_cnt_o + CNT_BITS'(1);
         end
         if (s1_lookup && match && !(&hit_cnt_o)) begin
            hit_cnt_o <= hit_cnt_o + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_sbp_lookup_stage_v2.sv
// Bench for sbp_lookup_stage_v2: an IPv4 instance with full-width counters
// and an IPv6 instance with 2-bit counters (so saturation is reachable).
// Each instance gets its own node memory with one-cycle read latency.
module tb_sbp_lookup_stage_v2;

   localparam int SB     = 6;
   localparam int LB     = 11;
   localparam int RB     = SB + LB;
   localparam int KB4    = 32;
   localparam int PB4    = 6;
   localparam int DB4    = KB4 + PB4 + SB + LB + 2;
   localparam int KB6    = 128;
   localparam int PB6    = 8;
   localparam int DB6    = KB6 + PB6 + SB + LB + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- IPv4 instance ----------------
   logic           v4 = 0, upd4 = 0, clr4 = 0;
   logic [KB4-1:0] key4 = '0;
   logic [PB4-1:0] bp4 = '0;
   logic [SB-1:0]  sid4 = '0;
   logic [LB-1:0]  loc4 = '0;
   logic [RB-1:0]  res4 = '0;
   logic           o4_v, o4_u, wr4, rd4;
   logic [KB4-1:0] o4_key;
   logic [PB4-1:0] o4_bp;
   logic [SB-1:0]  o4_sid;
   logic [LB-1:0]  o4_loc, addr4;
   logic [RB-1:0]  o4_res;
   logic [DB4-1:0] wdata4, rdata4;
   logic [31:0]    lcnt4, hcnt4;
   logic [DB4-1:0] mem4 [0:2047];

   sbp_lookup_stage_v2 #(.KEY_BITS(KB4)) u_dut4 (
      .clk(clk), .rst(rst), .valid_i(v4), .update_i(upd4), .key_i(key4),
      .bit_pos_i(bp4), .stage_id_i(sid4), .location_i(loc4), .result_i(res4),
      .valid_o(o4_v), .update_o(o4_u), .key_o(o4_key), .bit_pos_o(o4_bp),
      .stage_id_o(o4_sid), .location_o(o4_loc), .result_o(o4_res),
      .wr_en_o(wr4), .rd_en_o(rd4), .addr_o(addr4), .data_o(wdata4),
      .data_i(rdata4), .stat_clr_i(clr4), .lookup_cnt_o(lcnt4), .hit_cnt_o(hcnt4)
   );

   always @(posedge clk) begin
      if (wr4) mem4[addr4] <= wdata4;
      if (rd4) rdata4 <= mem4[addr4];
   end

   // ---------------- IPv6 instance ----------------
   logic           v6 = 0, upd6 = 0, clr6 = 0;
   logic [KB6-1:0] key6 = '0;
   logic [PB6-1:0] bp6 = '0;
   logic [SB-1:0]  sid6 = '0;
   logic [LB-1:0]  loc6 = '0;
   logic [RB-1:0]  res6 = '0;
   logic           o6_v, o6_u, wr6, rd6;
   logic [KB6-1:0] o6_key;
   logic [PB6-1:0] o6_bp;
   logic [SB-1:0]  o6_sid;
   logic [LB-1:0]  o6_loc, addr6;
   logic [RB-1:0]  o6_res;
   logic [DB6-1:0] wdata6, rdata6;
   logic [1:0]     lcnt6, hcnt6;
   logic [DB6-1:0] mem6 [0:2047];

   sbp_lookup_stage_v2 #(.KEY_BITS(KB6), .CNT_BITS(2)) u_dut6 (
      .clk(clk), .rst(rst), .valid_i(v6), .update_i(upd6), .key_i(key6),
      .bit_pos_i(bp6), .stage_id_i(sid6), .location_i(loc6), .result_i(res6),
      .valid_o(o6_v), .update_o(o6_u), .key_o(o6_key), .bit_pos_o(o6_bp),
      .stage_id_o(o6_sid), .location_o(o6_loc), .result_o(o6_res),
      .wr_en_o(wr6), .rd_en_o(rd6), .addr_o(addr6), .data_o(wdata6),
      .data_i(rdata6), .stat_clr_i(clr6), .lookup_cnt_o(lcnt6), .hit_cnt_o(hcnt6)
   );

   always @(posedge clk) begin
      if (wr6) mem6[addr6] <= wdata6;
      if (rd6) rdata6 <= mem6[addr6];
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect4(input string tag, input logic u, input logic [KB4-1:0] k,
                          input logic [PB4-1:0] bp, input logic [SB-1:0] sid,
                          input logic [LB-1:0] loc, input logic [RB-1:0] res);
      check({tag, ".valid"}, o4_v, 1'b1);
      check({tag, ".update"}, o4_u, u);
      check({tag, ".key"}, o4_key, k);
      check({tag, ".bit_pos"}, o4_bp, bp);
      check({tag, ".stage"}, o4_sid, sid);
      check({tag, ".loc"}, o4_loc, loc);
      check({tag, ".result"}, o4_res, res);
   endtask

   task automatic expect6(input string tag, input logic [KB6-1:0] k,
                          input logic [PB6-1:0] bp, input logic [SB-1:0] sid,
                          input logic [LB-1:0] loc, input logic [RB-1:0] res);
      check({tag, ".valid"}, o6_v, 1'b1);
      check({tag, ".update"}, o6_u, 1'b0);
      check({tag, ".key"}, o6_key, k);
      check({tag, ".bit_pos"}, o6_bp, bp);
      check({tag, ".stage"}, o6_sid, sid);
      check({tag, ".loc"}, o6_loc, loc);
      check({tag, ".result"}, o6_res, res);
   endtask

   // ---------------- drivers ----------------
   task automatic put4(input logic u, input logic [KB4-1:0] k, input logic [PB4-1:0] bp,
                       input logic [SB-1:0] sid, input logic [LB-1:0] loc, input logic [RB-1:0] res);
      v4 = 1'b1; upd4 = u; key4 = k; bp4 = bp; sid4 = sid; loc4 = loc; res4 = res;
      #1;
   endtask

   task automatic put6(input logic u, input logic [KB6-1:0] k, input logic [PB6-1:0] bp,
                       input logic [SB-1:0] sid, input logic [LB-1:0] loc, input logic [RB-1:0] res);
      v6 = 1'b1; upd6 = u; key6 = k; bp6 = bp; sid6 = sid; loc6 = loc; res6 = res;
      #1;
   endtask

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
      v4 = 1'b0; upd4 = 1'b0;
      v6 = 1'b0; upd6 = 1'b0;
   endtask

   localparam logic [KB6-1:0] P6  = 128'h2000_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [KB6-1:0] K6  = 128'h2001_0db8_0000_0000_0000_0000_0000_0001;

   // ---------------- directed vectors ----------------
   initial begin
      // Reset: a write beat presented during reset must not reach memory.
      put4(1'b1, 32'h0A00_0000, 6'd8, 6'd1, 11'd3, {6'd2, 11'd5});
      check("rst.wr_en", wr4, 1'b0);
      check("rst.rd_en", rd4, 1'b0);
      check("rst.data", wdata4, '0);
      check("rst.addr", addr4, '0);
      tick();
      tick();
      check("rst.valid_o", o4_v, 1'b0);
      check("rst.lookup_cnt", lcnt4, '0);
      check("rst.hit_cnt", hcnt4, '0);
      check("rst.v6_valid_o", o6_v, 1'b0);
      rst = 1'b0;

      // Write node {0x0A000000/8, child 2/5} at stage 1 location 3.
      put4(1'b1, 32'h0A00_0000, 6'd8, 6'd1, 11'd3, {6'd2, 11'd5});
      check("wr.wr_en", wr4, 1'b1);
      check("wr.rd_en", rd4, 1'b0);
      check("wr.addr", addr4, 11'd3);
      check("wr.data", wdata4, {32'h0A00_0000, 6'd8, 6'd2, 11'd5, 2'b11});
      tick();
      tick();
      expect4("wr.out", 1'b1, 32'h0A00_0000, 6'd8, 6'd1, 11'd3, {6'd2, 11'd5});
      check("wr.lookup_cnt", lcnt4, 32'd0);

      // Hit, left branch (key bit 23 = 0).
      put4(1'b0, 32'h0A01_0203, 6'd8, 6'd1, 11'd3, '0);
      check("hit.rd_en", rd4, 1'b1);
      check("hit.wr_en", wr4, 1'b0);
      check("hit.addr", addr4, 11'd3);
      tick();
      tick();
      expect4("hit", 1'b0, 32'h0A01_0203, 6'd9, 6'd2, 11'd5, {6'd1, 11'd3});
      check("hit.lookup_cnt", lcnt4, 32'd1);
      check("hit.hit_cnt", hcnt4, 32'd1);

      // Miss: result_i passes, only lookup count moves.
      put4(1'b0, 32'h0B00_0000, 6'd8, 6'd1, 11'd3, 17'h01234);
      tick();
      tick();
      expect4("miss", 1'b0, 32'h0B00_0000, 6'd9, 6'd2, 11'd5, 17'h01234);
      check("miss.lookup_cnt", lcnt4, 32'd2);
      check("miss.hit_cnt", hcnt4, 32'd1);

      // Hit, right branch (key bit 23 = 1) -> child location + 1.
      put4(1'b0, 32'h0A80_0000, 6'd8, 6'd1, 11'd3, '0);
      tick();
      tick();
      expect4("right", 1'b0, 32'h0A80_0000, 6'd9, 6'd2, 11'd6, {6'd1, 11'd3});
      check("right.hit_cnt", hcnt4, 32'd2);

      // Prefix length 0 always matches; bit_pos 32 selects left, becomes 33.
      put4(1'b1, 32'h1234_5678, 6'd0, 6'd1, 11'd7, {6'd4, 11'd10});
      tick();
      tick();
      put4(1'b0, 32'hFFFF_FFFF, 6'd32, 6'd1, 11'd7, '0);
      tick();
      tick();
      expect4("len0", 1'b0, 32'hFFFF_FFFF, 6'd33, 6'd4, 11'd10, {6'd1, 11'd7});
      check("len0.lookup_cnt", lcnt4, 32'd4);
      check("len0.hit_cnt", hcnt4, 32'd3);

      // Prefix length 40 > 32 never matches; bit_pos 63 saturates.
      put4(1'b1, 32'h0A00_0000, 6'd40, 6'd1, 11'd9, {6'd3, 11'd20});
      tick();
      tick();
      put4(1'b0, 32'h0A00_0000, 6'd63, 6'd1, 11'd9, 17'h00055);
      tick();
      tick();
      expect4("len40", 1'b0, 32'h0A00_0000, 6'd63, 6'd3, 11'd20, 17'h00055);
      check("len40.lookup_cnt", lcnt4, 32'd5);
      check("len40.hit_cnt", hcnt4, 32'd3);

      // Beat for stage 7 passes untouched and issues no memory access.
      put4(1'b0, 32'hDEAD_BEEF, 6'd5, 6'd7, 11'd3, 17'h1F0F0);
      check("foreign.rd_en", rd4, 1'b0);
      check("foreign.wr_en", wr4, 1'b0);
      tick();
      tick();
      expect4("foreign", 1'b0, 32'hDEAD_BEEF, 6'd5, 6'd7, 11'd3, 17'h1F0F0);
      check("foreign.lookup_cnt", lcnt4, 32'd5);

      // Reset with two beats in flight: neither may emerge.
      put4(1'b0, 32'h0A01_0203, 6'd8, 6'd1, 11'd3, '0);
      tick();
      put4(1'b0, 32'h0B00_0000, 6'd8, 6'd1, 11'd3, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("flight.valid_o_a", o4_v, 1'b0);
      check("flight.lookup_cnt", lcnt4, 32'd0);
      tick();
      check("flight.valid_o_b", o4_v, 1'b0);

      // Clean restart with back-to-back beats.
      put4(1'b0, 32'h0A01_0203, 6'd8, 6'd1, 11'd3, '0);
      tick();
      put4(1'b0, 32'h0B00_0000, 6'd8, 6'd1, 11'd3, 17'h00ABC);
      tick();
      expect4("b2b_a", 1'b0, 32'h0A01_0203, 6'd9, 6'd2, 11'd5, {6'd1, 11'd3});
      check("b2b_a.hit_cnt", hcnt4, 32'd1);
      tick();
      expect4("b2b_b", 1'b0, 32'h0B00_0000, 6'd9, 6'd2, 11'd5, 17'h00ABC);
      check("b2b_b.lookup_cnt", lcnt4, 32'd2);
      check("b2b_b.hit_cnt", hcnt4, 32'd1);

      // IPv6: same node shape, /8 prefix 2000::.
      put6(1'b1, P6, 8'd8, 6'd1, 11'd3, {6'd2, 11'd5});
      check("v6wr.data", wdata6, {P6, 8'd8, 6'd2, 11'd5, 2'b11});
      tick();
      tick();
      put6(1'b0, K6, 8'd8, 6'd1, 11'd3, '0);
      tick();
      tick();
      expect6("v6hit", K6, 8'd9, 6'd2, 11'd5, {6'd1, 11'd3});
      check("v6hit.lookup_cnt", lcnt6, 2'd1);
      check("v6hit.hit_cnt", hcnt6, 2'd1);

      // Last key bit (bit_pos 127) is 1 -> right child.
      put6(1'b0, K6, 8'd127, 6'd1, 11'd3, '0);
      tick();
      tick();
      expect6("v6lsb", K6, 8'd128, 6'd2, 11'd6, {6'd1, 11'd3});

      put6(1'b0, K6, 8'd8, 6'd1, 11'd3, '0);
      tick();
      tick();
      check("v6sat3.lookup_cnt", lcnt6, 2'd3);
      check("v6sat3.hit_cnt", hcnt6, 2'd3);

      // All-ones counters plus another hit stay all-ones.
      put6(1'b0, K6, 8'd8, 6'd1, 11'd3, '0);
      tick();
      tick();
      check("v6sat.lookup_cnt", lcnt6, 2'd3);
      check("v6sat.hit_cnt", hcnt6, 2'd3);

      // Clear coinciding with a hit's counting edge wins.
      put6(1'b0, K6, 8'd8, 6'd1, 11'd3, '0);
      tick();
      clr6 = 1'b1;
      tick();
      clr6 = 1'b0;
      check("v6clr.valid_o", o6_v, 1'b1);
      check("v6clr.lookup_cnt", lcnt6, 2'd0);
      check("v6clr.hit_cnt", hcnt6, 2'd0);
      check("v6clr.v4_untouched", lcnt4, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sbp_lookup_stage_v2.md
SBP_LOOKUP_STAGE_V2 -- requirements
Module: sbp_lookup_stage_v2

Interface
REQ-001 SHALL have parameter STAGE_ID, default 1: stage number this instance serves.
REQ-002 SHALL have parameter STAGE_ID_BITS, default 6: stage id width.
REQ-003 SHALL have parameter LOCATION_BITS, default 11: node location width, equal to memory address width.
REQ-004 SHALL have parameter KEY_BITS, default 32: key/prefix width; only 32 (IPv4) and 128 (IPv6) legal, anything else is an elaboration error.
REQ-005 SHALL have parameter CNT_BITS, default 32: statistics counter width.
REQ-006 SHALL derive PLEN_BITS = clog2(KEY_BITS)+1, RESULT_BITS = STAGE_ID_BITS+LOCATION_BITS, DATA_BITS = KEY_BITS+PLEN_BITS+STAGE_ID_BITS+LOCATION_BITS+2.
REQ-007 SHALL have ports, one clock; reset is synchronous and active-high:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  input beat valid
update_i  in  1  beat is a table write
key_i  in  KEY_BITS  lookup key, or prefix to write
bit_pos_i  in  PLEN_BITS  next bit to test, or prefix length to write
stage_id_i  in  STAGE_ID_BITS  target stage
location_i  in  LOCATION_BITS  target location
result_i  in  RESULT_BITS  best match so far, or child pointer to write
valid_o, update_o, key_o, bit_pos_o, stage_id_o, location_o, result_o  out  same widths  pipelined beat
wr_en_o  out  1  memory write enable
rd_en_o  out  1  memory read enable
addr_o  out  LOCATION_BITS  memory address
data_o  out  DATA_BITS  memory write data
data_i  in  DATA_BITS  memory read data, one cycle after rd_en_o
stat_clr_i  in  1  clear statistics counters
lookup_cnt_o, hit_cnt_o  out  CNT_BITS  statistics

Function
REQ-008 SHALL pack memory word MSB-first as {prefix, prefix_len, child_stage, child_location, has_left, has_right}, no padding.
REQ-009 SHALL set sel = valid_i && stage_id_i == STAGE_ID (combinational); wr_en_o = sel && update_i; rd_en_o = sel && !update_i; addr_o = location_i.
REQ-010 SHALL drive data_o = {key_i, bit_pos_i, result_i, 2'b11} on write beats; write outputs SHALL be 0 while rst is high.
REQ-011 SHALL have fixed latency 2: beat accepted in cycle N appears on outputs in cycle N+2; one beat per cycle, no backpressure.
REQ-012 SHALL pass valid, update and key through unchanged; non-selected, update, or invalid beats SHALL pass every field unchanged.
REQ-013 SHALL compute match = top prefix_len bits of key equal top prefix_len bits of prefix; prefix_len 0 always matches; prefix_len > KEY_BITS never matches.
REQ-014 SHALL compute right_sel = key bit (KEY_BITS-1-bit_pos); right_sel = 0 when bit_pos >= KEY_BITS.
REQ-015 SHALL, for a selected lookup, output bit_pos+1 (saturating at 2^PLEN_BITS-1) and location = child_location + right_sel (mod 2^LOCATION_BITS).
REQ-016 SHALL output stage_id = child_stage when the selected child exists (has_left && !right_sel or has_right && right_sel), else stage_id_i.
REQ-017 SHALL output result = {STAGE_ID, location_i} on a selected-lookup match, else result_i.
REQ-018 SHALL increment lookup_cnt_o on each selected lookup, and hit_cnt_o on each selected-lookup match, in the output cycle; both SHALL saturate at all-ones.
REQ-019 SHALL give stat_clr_i priority over a same-cycle increment: the counter becomes 0.

Reset
REQ-020 SHALL force all outputs and counters to 0 in the cycle after rst is sampled high.
REQ-021 SHALL discard beats in flight during reset and restart cleanly with the first valid_i after rst falls.

Verification
REQ-022 Write {prefix 0x0A000000, len 8, child 2/5, LR=11} at stage 1 loc 3; lookup key 0x0A010203, bit_pos 8, loc 3 -> at N+2: bit_pos 9, stage 2, loc 5, result {1,3}, hit_cnt 1.
REQ-023 Same entry, key 0x0B000000 -> no match: result_i passed, lookup_cnt increments, hit_cnt unchanged.
REQ-024 Prefix len 0 -> always matches; bit_pos 32 with KEY_BITS=32 -> right_sel 0, bit_pos_o 33.
REQ-025 Beat for stage 7 at stage 1 -> no rd/wr enable, all fields passed unchanged at N+2.
REQ-026 Counters at all-ones plus hit -> stay all-ones; stat_clr_i with a same-cycle hit -> 0.
REQ-027 Assert rst with 2 beats in flight -> valid_o 0 for both; KEY_BITS=128 rerun of REQ-022 with an IPv6 prefix gives the same results.
